// File: rtl/rotor_step_ctrl.sv
// -----------------------------------------------------------------------------
// rotor_step_ctrl
//
// Keypress sequencer for a three-rotor Enigma datapath. It holds the rotor
// offsets, accepts one key letter per transaction, steps the rotors with the
// odometer rule (including the middle-rotor double-step), holds the letter and
// offsets steady while the external rotor/reflector chain settles, then
// returns the enciphered letter over a valid/ready handshake.
//
// Transaction flow: IDLE -> STEP -> WAIT -> DONE -> IDLE
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   cfg_load, cfg_fast/mid/slow   start-position load, honoured only in IDLE
//   cfg_err                       1-cycle pulse: a start position was >= 26
//   key_valid, key_letter         key letter in, 1..26 = A..Z
//   key_ready                     IDLE and no cfg_load this cycle
//   key_err                       1-cycle pulse: accepted key outside 1..26
//   rot_fast, rot_mid, rot_slow   rotate offsets to the rotor chain
//   enc_letter                    letter driven into the rotor chain
//   enc_result                    letter returned by the rotor chain
//   out_valid, out_letter         enciphered letter, held until out_ready
//   out_ready                     consumer accepts out_letter
//   busy                          high in any state other than IDLE
// -----------------------------------------------------------------------------
module rotor_step_ctrl #(
   parameter int unsigned NOTCH_FAST = 21,
   parameter int unsigned NOTCH_MID  = 4,
   parameter int unsigned ENC_LAT    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_load,
   input  logic [4:0] cfg_fast,
   input  logic [4:0] cfg_mid,
   input  logic [4:0] cfg_slow,
   output logic       cfg_err,
   input  logic       key_valid,
   input  logic [4:0] key_letter,
   output logic       key_ready,
   output logic       key_err,
   output logic [4:0] rot_fast,
   output logic [4:0] rot_mid,
   output logic [4:0] rot_slow,
   output logic [4:0] enc_letter,
   input  logic [4:0] enc_result,
   output logic       out_valid,
   output logic [4:0] out_letter,
   input  logic       out_ready,
   output logic       busy
);

   localparam logic [4:0] NotchFast = 5'(NOTCH_FAST);
   localparam logic [4:0] NotchMid  = 5'(NOTCH_MID);
   localparam logic [3:0] EncLat    = 4'(ENC_LAT);
   localparam logic [4:0] NumPos    = 5'd26;

   typedef enum logic [1:0] {
      StIdle,
      StStep,
      StWait,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [4:0] fast_q, fast_d;
   logic [4:0] mid_q, mid_d;
   logic [4:0] slow_q, slow_d;
   logic [4:0] enc_letter_q, enc_letter_d;
   logic [4:0] out_letter_q, out_letter_d;
   logic       out_valid_q, out_valid_d;
   logic [3:0] cnt_q, cnt_d;
   logic       key_err_q, key_err_d;
   logic       cfg_err_q, cfg_err_d;

   logic       key_ok;
   logic       fast_bad, mid_bad, slow_bad;
   logic       fast_at_notch, mid_at_notch;

   // Advance one rotor position modulo 26. The sum is formed at 6 bits so the
   // carry out of 5 bits can never alias back into range.
   function automatic logic [4:0] inc26(input logic [4:0] v);
      logic [5:0] sum;
      sum = {1'b0, v} + 6'd1;
      if (sum >= 6'd26) begin
         sum = 6'd0;
      end
      return sum[4:0];
   endfunction

   assign key_ok   = (key_letter != 5'd0) && (key_letter <= 5'd26);
   assign fast_bad = (cfg_fast >= NumPos);
   assign mid_bad  = (cfg_mid  >= NumPos);
   assign slow_bad = (cfg_slow >= NumPos);

   // Notch decisions use the positions before this step.
   assign fast_at_notch = (fast_q == NotchFast);
   assign mid_at_notch  = (mid_q  == NotchMid);

   always_comb begin
      state_d      = state_q;
      fast_d       = fast_q;
      mid_d        = mid_q;
      slow_d       = slow_q;
      enc_letter_d = enc_letter_q;
      out_letter_d = out_letter_q;
      out_valid_d  = out_valid_q;
      cnt_d        = cnt_q;
      key_err_d    = 1'b0;
      cfg_err_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            // cfg_load wins over a key presented in the same cycle.
            if (cfg_load) begin
               fast_d    = fast_bad ? 5'd0 : cfg_fast;
               mid_d     = mid_bad  ? 5'd0 : cfg_mid;
               slow_d    = slow_bad ? 5'd0 : cfg_slow;
               cfg_err_d = fast_bad | mid_bad | slow_bad;
            end else if (key_valid) begin
               if (key_ok) begin
                  enc_letter_d = key_letter;
                  state_d      = StStep;
               end else begin
                  key_err_d = 1'b1;
               end
            end
         end

         StStep: begin
            fast_d = inc26(fast_q);
            // Middle rotor steps on the fast notch, and also on its own notch:
            // the latter is the double-step that carries the slow rotor too.
            if (fast_at_notch || mid_at_notch) begin
               mid_d = inc26(mid_q);
            end
            if (mid_at_notch) begin
               slow_d = inc26(slow_q);
            end
            cnt_d   = EncLat;
            state_d = StWait;
         end

         StWait: begin
            if (cnt_q == 4'd0) begin
               out_letter_d = enc_result;
               out_valid_d  = 1'b1;
               state_d      = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         fast_q       <= 5'd0;
         mid_q        <= 5'd0;
         slow_q       <= 5'd0;
         enc_letter_q <= 5'd0;
         out_letter_q <= 5'd0;
         out_valid_q  <= 1'b0;
         cnt_q        <= 4'd0;
         key_err_q    <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fast_q       <= fast_d;
         mid_q        <= mid_d;
         slow_q       <= slow_d;
         enc_letter_q <= enc_letter_d;
         out_letter_q <= out_letter_d;
         out_valid_q  <= out_valid_d;
         cnt_q        <= cnt_d;
         key_err_q    <= key_err_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign key_ready  = (state_q == StIdle) && !cfg_load;
   assign busy       = (state_q != StIdle);
   assign rot_fast   = fast_q;
   assign rot_mid    = mid_q;
   assign rot_slow   = slow_q;
   assign enc_letter = enc_letter_q;
   assign out_letter = out_letter_q;
   assign out_valid  = out_valid_q;
   assign key_err    = key_err_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_rotor_step_ctrl.sv
module tb_rotor_step_ctrl;

   localparam int NF      = 21;
   localparam int NM      = 4;
   localparam int ENC_LAT = 1;

   logic       clk;
   logic       rst_n;
   logic       cfg_load;
   logic [4:0] cfg_fast, cfg_mid, cfg_slow;
   logic       cfg_err;
   logic       key_valid;
   logic [4:0] key_letter;
   logic       key_ready;
   logic       key_err;
   logic [4:0] rot_fast, rot_mid, rot_slow;
   logic [4:0] enc_letter;
   logic [4:0] enc_result;
   logic       out_valid;
   logic [4:0] out_letter;
   logic       out_ready;
   logic       busy;

   rotor_step_ctrl #(
      .NOTCH_FAST(NF),
      .NOTCH_MID (NM),
      .ENC_LAT   (ENC_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_load  (cfg_load),
      .cfg_fast  (cfg_fast),
      .cfg_mid   (cfg_mid),
      .cfg_slow  (cfg_slow),
      .cfg_err   (cfg_err),
      .key_valid (key_valid),
      .key_letter(key_letter),
      .key_ready (key_ready),
      .key_err   (key_err),
      .rot_fast  (rot_fast),
      .rot_mid   (rot_mid),
      .rot_slow  (rot_slow),
      .enc_letter(enc_letter),
      .enc_result(enc_result),
      .out_valid (out_valid),
      .out_letter(out_letter),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Stand-in rotor chain: a letter-and-offset dependent substitution.
   function automatic int chain(input int k, input int f, input int m, input int s);
      return ((k + 25) + f + 3 * m + 7 * s) % 26 + 1;
   endfunction

   always_comb enc_result = 5'(chain(int'(enc_letter), int'(rot_fast), int'(rot_mid),
                                     int'(rot_slow)));

   // Transaction-level model: rotor positions and the key in flight.
   int m_f = 0, m_m = 0, m_s = 0, m_key = 0;

   function automatic int wrap(input int v);
      return v % 26;
   endfunction

   task automatic model_step();
      int nf, nm, ns;
      nf = wrap(m_f + 1);
      nm = (m_f == NF || m_m == NM) ? wrap(m_m + 1) : m_m;
      ns = (m_m == NM) ? wrap(m_s + 1) : m_s;
      m_f = nf;
      m_m = nm;
      m_s = ns;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Whenever a result is presented, it and the offsets it was formed from
   // must agree with the model.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         chk("cmp_out_letter", int'(out_letter), chain(m_key, m_f, m_m, m_s));
         chk("cmp_rot_fast", int'(rot_fast), m_f);
         chk("cmp_rot_mid", int'(rot_mid), m_m);
         chk("cmp_rot_slow", int'(rot_slow), m_s);
         chk("cmp_enc_letter", int'(enc_letter), m_key);
         chk("cmp_busy", int'(busy), 1);
      end
   end

   task automatic load(input int f, input int m, input int s, input int exp_err);
      @(negedge clk);
      cfg_load = 1'b1;
      cfg_fast = 5'(f);
      cfg_mid  = 5'(m);
      cfg_slow = 5'(s);
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      m_f = (f < 26) ? f : 0;
      m_m = (m < 26) ? m : 0;
      m_s = (s < 26) ? s : 0;
      chk("cfg_err_pulse", int'(cfg_err), exp_err);
      chk("load_fast", int'(rot_fast), m_f);
      chk("load_mid", int'(rot_mid), m_m);
      chk("load_slow", int'(rot_slow), m_s);
      @(posedge clk);
      #1;
      chk("cfg_err_clear", int'(cfg_err), 0);
   endtask

   // Present one valid key and wait for the result to appear.
   task automatic key(input int k);
      int n;
      bit seen;
      n = 0;
      while (!key_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("key_ready_wait", int'(key_ready), 1);
      @(negedge clk);
      key_valid  = 1'b1;
      key_letter = 5'(k);
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      model_step();
      m_key = k;
      chk("busy_after_accept", int'(busy), 1);
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (out_valid) seen = 1'b1;
      end
      chk("out_valid_latency", n, ENC_LAT + 2);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (busy && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("return_idle", int'(busy), 0);
      chk("out_valid_cleared", int'(out_valid), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] held;
      rst_n      = 1'b0;
      cfg_load   = 1'b0;
      cfg_fast   = 5'd0;
      cfg_mid    = 5'd0;
      cfg_slow   = 5'd0;
      key_valid  = 1'b0;
      key_letter = 5'd0;
      out_ready  = 1'b1;
      #1;
      chk("rst_rot_fast", int'(rot_fast), 0);
      chk("rst_rot_mid", int'(rot_mid), 0);
      chk("rst_rot_slow", int'(rot_slow), 0);
      chk("rst_enc_letter", int'(enc_letter), 0);
      chk("rst_out_letter", int'(out_letter), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_key_err", int'(key_err), 0);
      chk("rst_cfg_err", int'(cfg_err), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_key_ready", int'(key_ready), 1);

      // Reset asserted while a transaction sits in WAIT.
      load(5, 6, 7, 0);
      @(negedge clk);
      key_valid  = 1'b1;
      key_letter = 5'd7;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_rot_fast", int'(rot_fast), 6);
      rst_n = 1'b0;
      #1;
      chk("async_rst_fast", int'(rot_fast), 0);
      chk("async_rst_mid", int'(rot_mid), 0);
      chk("async_rst_slow", int'(rot_slow), 0);
      chk("async_rst_out_valid", int'(out_valid), 0);
      chk("async_rst_busy", int'(busy), 0);
      #2;
      rst_n = 1'b1;
      m_f = 0;
      m_m = 0;
      m_s = 0;
      @(posedge clk);
      #1;
      chk("rst_release_key_ready", int'(key_ready), 1);

      // Basic encryption from 0/0/0.
      load(0, 0, 0, 0);
      key(1);
      chk("t2_fast", int'(rot_fast), 1);
      chk("t2_mid", int'(rot_mid), 0);
      chk("t2_slow", int'(rot_slow), 0);
      chk("t2_letter", int'(out_letter), 2);
      drain();

      // Fast-rotor notch carries the middle rotor.
      load(21, 0, 0, 0);
      key(5);
      chk("t3_fast", int'(rot_fast), 22);
      chk("t3_mid", int'(rot_mid), 1);
      chk("t3_slow", int'(rot_slow), 0);
      chk("t3_letter", int'(out_letter), 4);
      drain();

      // Double-step.
      load(21, 3, 0, 0);
      key(2);
      chk("t4a_fast", int'(rot_fast), 22);
      chk("t4a_mid", int'(rot_mid), 4);
      chk("t4a_slow", int'(rot_slow), 0);
      drain();
      key(3);
      chk("t4b_fast", int'(rot_fast), 23);
      chk("t4b_mid", int'(rot_mid), 5);
      chk("t4b_slow", int'(rot_slow), 1);
      drain();

      // Wrap-around.
      load(25, 25, 25, 0);
      key(26);
      chk("t5a_fast", int'(rot_fast), 0);
      chk("t5a_mid", int'(rot_mid), 25);
      chk("t5a_slow", int'(rot_slow), 25);
      drain();
      load(10, 4, 25, 0);
      key(4);
      chk("t5b_fast", int'(rot_fast), 11);
      chk("t5b_mid", int'(rot_mid), 5);
      chk("t5b_slow", int'(rot_slow), 0);
      drain();

      // Backpressure: result held, further keys ignored.
      out_ready = 1'b0;
      key(8);
      held = out_letter;
      chk("t6_fast", int'(rot_fast), 12);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         key_valid  = 1'b1;
         key_letter = 5'd9;
         @(posedge clk);
         #1;
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_out_letter", int'(out_letter), int'(held));
         chk("hold_key_ready", int'(key_ready), 0);
      end
      @(negedge clk);
      key_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out_valid", int'(out_valid), 0);
      chk("release_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      chk("idle_ready_ignored", int'(out_valid), 0);

      // Bad key letters.
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         key_valid  = 1'b1;
         key_letter = (b == 0) ? 5'd0 : 5'd27;
         @(posedge clk);
         #1;
         key_valid = 1'b0;
         chk("key_err_pulse", int'(key_err), 1);
         chk("key_err_busy", int'(busy), 0);
         chk("key_err_fast", int'(rot_fast), m_f);
         chk("key_err_mid", int'(rot_mid), m_m);
         @(posedge clk);
         #1;
         chk("key_err_clear", int'(key_err), 0);
      end

      // Out-of-range start position.
      load(30, 2, 3, 1);

      // cfg_load beats a simultaneous key.
      @(negedge clk);
      cfg_load   = 1'b1;
      cfg_fast   = 5'd1;
      cfg_mid    = 5'd2;
      cfg_slow   = 5'd3;
      key_valid  = 1'b1;
      key_letter = 5'd5;
      #1;
      chk("prio_key_ready", int'(key_ready), 0);
      @(posedge clk);
      #1;
      cfg_load  = 1'b0;
      key_valid = 1'b0;
      m_f = 1;
      m_m = 2;
      m_s = 3;
      chk("prio_busy", int'(busy), 0);
      chk("prio_fast", int'(rot_fast), 1);
      chk("prio_slow", int'(rot_slow), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
